// File: rtl/queue_msg_reader.sv
// Drains length-prefixed messages from a first-word-fall-through FIFO.
// Payload words go out on a registered valid/ready stream, marked with start and end of message.
module queue_msg_reader #(
    parameter int DATA_SIZE  = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int MAX_LEN    = 64,
    parameter int TYPE_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  q_empty,
    input  logic [DATA_SIZE-1:0]  q_pop_data,
    output logic                  q_pop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_SIZE-1:0]  out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [TYPE_WIDTH-1:0] out_type,
    output logic                  len_err,
    output logic [CNT_WIDTH-1:0]  msg_count,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  fsm_state
);

    typedef enum logic {
        HDR     = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] remaining;
    logic [LEN_WIDTH-1:0] msg_len;
    logic [LEN_WIDTH-1:0] hdr_len;
    logic                 hdr_ok;
    logic                 slot_free;
    logic                 accept;

    // Handshake: a word transfers on a cycle with out_valid && out_ready. Once out_valid
    // rises, out_data/out_sop/out_eop hold until that transfer. The register may be reloaded
    // in the same cycle that its current word transfers.
    assign slot_free = !out_valid || out_ready;
    assign accept    = out_valid && out_ready;

    assign hdr_len = q_pop_data[LEN_WIDTH-1:0];
    assign hdr_ok  = (hdr_len != '0) && (hdr_len <= LEN_WIDTH'(MAX_LEN));

    // Headers never touch the output register, so they pop even while an eop word waits.
    assign q_pop     = (state == HDR) ? !q_empty : (!q_empty && slot_free);
    assign fsm_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HDR;
            remaining <= '0;
            msg_len   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_type  <= '0;
            len_err   <= 1'b0;
            msg_count <= '0;
            err_count <= '0;
        end else begin
            len_err <= 1'b0;
            if (accept && out_eop) begin
                msg_count <= msg_count + CNT_WIDTH'(1);
            end
            if (accept) begin
                out_valid <= 1'b0;
            end
            case (state)
                HDR: begin
                    if (q_pop) begin
                        if (hdr_ok) begin
                            out_type  <= q_pop_data[DATA_SIZE-1 -: TYPE_WIDTH];
                            remaining <= hdr_len;
                            msg_len   <= hdr_len;
                            state     <= PAYLOAD;
                        end else begin
                            len_err   <= 1'b1;
                            err_count <= err_count + CNT_WIDTH'(1);
                        end
                    end
                end
                PAYLOAD: begin
                    if (q_pop) begin
                        out_data  <= q_pop_data;
                        out_valid <= 1'b1;
                        out_sop   <= (remaining == msg_len);
                        out_eop   <= (remaining == LEN_WIDTH'(1));
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == LEN_WIDTH'(1)) begin
                            state <= HDR;
                        end
                    end
                end
                default: state <= HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_queue_msg_reader.sv
// Directed bench for queue_msg_reader: a queue-backed FWFT FIFO model feeds the reader.
// An edge monitor logs pops, accepted words and len_err pulses with their cycle numbers.
module tb_queue_msg_reader;

    logic        clk;
    logic        reset;
    logic        q_empty;
    logic [31:0] q_pop_data;
    logic        q_pop;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic [7:0]  out_type;
    logic        len_err;
    logic [15:0] msg_count;
    logic [15:0] err_count;
    logic        fsm_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int underrun_pops = 0;

    logic [31:0] fifo[$];
    logic [31:0] acc_data[$];
    logic        acc_sop[$];
    logic        acc_eop[$];
    logic [7:0]  acc_type[$];
    int          acc_cyc[$];
    int          pop_cyc[$];
    int          err_cyc[$];

    queue_msg_reader dut (
        .clk(clk), .reset(reset), .q_empty(q_empty), .q_pop_data(q_pop_data), .q_pop(q_pop),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sop(out_sop),
        .out_eop(out_eop), .out_type(out_type), .len_err(len_err), .msg_count(msg_count),
        .err_count(err_count), .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- fifo model and monitor ----------------
    task automatic refresh();
        q_empty    = (fifo.size() == 0);
        q_pop_data = q_empty ? 32'h0 : fifo[0];
    endtask

    task automatic push(input logic [31:0] w);
        fifo.push_back(w);
        refresh();
    endtask

    function automatic logic [31:0] hdr(input logic [7:0] t, input logic [7:0] l);
        return {t, 16'h0000, l};
    endfunction

    task automatic clear_logs();
        acc_data.delete(); acc_sop.delete(); acc_eop.delete(); acc_type.delete();
        acc_cyc.delete(); pop_cyc.delete(); err_cyc.delete();
        underrun_pops = 0;
    endtask

    always @(posedge clk) begin
        if (q_pop && q_empty) underrun_pops++;
        if (q_pop && !q_empty) begin
            pop_cyc.push_back(cyc);
            fifo.delete(0);
        end
        if (out_valid && out_ready) begin
            acc_data.push_back(out_data);
            acc_sop.push_back(out_sop);
            acc_eop.push_back(out_eop);
            acc_type.push_back(out_type);
            acc_cyc.push_back(cyc);
        end
        if (len_err) err_cyc.push_back(cyc);
        cyc++;
        #1 refresh();
    end

    // ---------------- driver helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        fifo.delete();
        refresh();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic wait_acc(input int n, input string what);
        int k = 0;
        while (acc_data.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (acc_data.size() < n) begin
            errors++;
            $display("FAIL %s timeout: got %0d words, required %0d", what, acc_data.size(), n);
        end
    endtask

    task automatic wait_valid(input string what);
        int k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL %s timeout waiting for out_valid", what);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        out_ready = 1'b1;
        refresh();
        #1;
        checks++;
        if ({out_valid, out_sop, out_eop, len_err, fsm_state, q_pop} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 000000",
                     {out_valid, out_sop, out_eop, len_err, fsm_state, q_pop});
        end
        checks++;
        if ({out_data, out_type, msg_count, err_count} !== 72'h0) begin
            errors++;
            $display("FAIL reset_regs: data=%h type=%h msg=%0d err=%0d, required all 0",
                     out_data, out_type, msg_count, err_count);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_logs();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || fsm_state !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: valid=%b state=%b, required 0/0", out_valid, fsm_state);
        end
    endtask

    task automatic test_basic();
        do_reset();
        push(hdr(8'h5A, 8'd3)); push(32'hAAAA_0001); push(32'hBBBB_0002); push(32'hCCCC_0003);
        wait_acc(3, "basic");
        @(negedge clk);
        checks++;
        if (pop_cyc.size() != 4 || pop_cyc[1] != pop_cyc[0] + 1 || pop_cyc[2] != pop_cyc[0] + 2
            || pop_cyc[3] != pop_cyc[0] + 3) begin
            errors++;
            $display("FAIL basic_pops: got %0d pops, required 4 on consecutive cycles", pop_cyc.size());
        end
        checks++;
        if (acc_cyc[0] != pop_cyc[0] + 2 || acc_cyc[1] != pop_cyc[0] + 3 || acc_cyc[2] != pop_cyc[0] + 4) begin
            errors++;
            $display("FAIL basic_timing: first pop %0d, words at %0d %0d %0d, required +2 +3 +4",
                     pop_cyc[0], acc_cyc[0], acc_cyc[1], acc_cyc[2]);
        end
        checks++;
        if (acc_data[0] !== 32'hAAAA_0001 || acc_data[1] !== 32'hBBBB_0002 || acc_data[2] !== 32'hCCCC_0003) begin
            errors++;
            $display("FAIL basic_data: got %h %h %h, required aaaa0001 bbbb0002 cccc0003",
                     acc_data[0], acc_data[1], acc_data[2]);
        end
        checks++;
        if ({acc_sop[0], acc_eop[0], acc_sop[1], acc_eop[1], acc_sop[2], acc_eop[2]} !== 6'b10_00_01) begin
            errors++;
            $display("FAIL basic_markers: got %b, required 100001",
                     {acc_sop[0], acc_eop[0], acc_sop[1], acc_eop[1], acc_sop[2], acc_eop[2]});
        end
        checks++;
        if (acc_type[0] !== 8'h5A || acc_type[1] !== 8'h5A || acc_type[2] !== 8'h5A || msg_count !== 16'd1) begin
            errors++;
            $display("FAIL basic_type_count: type %h %h %h msg=%0d, required 5a and 1",
                     acc_type[0], acc_type[1], acc_type[2], msg_count);
        end
    endtask

    task automatic test_stall();
        int bad = 0;
        int rise;
        do_reset();
        out_ready = 1'b0;
        push(hdr(8'h5A, 8'd3)); push(32'hAAAA_0001); push(32'hBBBB_0002); push(32'hCCCC_0003);
        wait_valid("stall");
        for (int i = 0; i < 5; i++) begin
            if (out_data !== 32'hAAAA_0001 || !out_valid || !out_sop || q_pop !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: %0d bad cycles, required 0", bad);
        end
        rise = cyc;
        out_ready = 1'b1;
        wait_acc(3, "stall");
        @(negedge clk);
        checks++;
        if (acc_data.size() != 3 || acc_data[0] !== 32'hAAAA_0001 || acc_data[1] !== 32'hBBBB_0002
            || acc_data[2] !== 32'hCCCC_0003) begin
            errors++;
            $display("FAIL stall_data: got %0d words, first %h, required 3 words A B C",
                     acc_data.size(), acc_data[0]);
        end
        checks++;
        if (acc_cyc[0] != rise || acc_cyc[1] != rise + 1 || acc_cyc[2] != rise + 2 || msg_count !== 16'd1) begin
            errors++;
            $display("FAIL stall_timing: words at %0d %0d %0d msg=%0d, required %0d %0d %0d and 1",
                     acc_cyc[0], acc_cyc[1], acc_cyc[2], msg_count, rise, rise + 1, rise + 2);
        end
    endtask

    task automatic test_len_err();
        do_reset();
        push(hdr(8'h11, 8'd0));  push(hdr(8'h22, 8'd1)); push(32'hD000_0001);
        push(hdr(8'h33, 8'd65)); push(hdr(8'h44, 8'd1)); push(32'hD000_0002);
        wait_acc(2, "len_err");
        repeat (2) @(negedge clk);
        checks++;
        if (err_count !== 16'd2 || err_cyc.size() != 2 || msg_count !== 16'd2) begin
            errors++;
            $display("FAIL len_err_counts: err=%0d pulses=%0d msg=%0d, required 2 2 2",
                     err_count, err_cyc.size(), msg_count);
        end
        checks++;
        if (err_cyc[0] != pop_cyc[0] + 1 || err_cyc[1] != pop_cyc[0] + 4) begin
            errors++;
            $display("FAIL len_err_timing: pulses at %0d %0d, required %0d %0d",
                     err_cyc[0], err_cyc[1], pop_cyc[0] + 1, pop_cyc[0] + 4);
        end
        checks++;
        if (acc_data[0] !== 32'hD000_0001 || acc_data[1] !== 32'hD000_0002
            || {acc_sop[0], acc_eop[0], acc_sop[1], acc_eop[1]} !== 4'b1111
            || acc_type[0] !== 8'h22 || acc_type[1] !== 8'h44) begin
            errors++;
            $display("FAIL len_err_words: got %h %h markers %b types %h %h, required d0000001 d0000002 1111 22 44",
                     acc_data[0], acc_data[1], {acc_sop[0], acc_eop[0], acc_sop[1], acc_eop[1]},
                     acc_type[0], acc_type[1]);
        end
    endtask

    task automatic test_max_len();
        int bad = 0;
        do_reset();
        push(hdr(8'h40, 8'd64));
        for (int i = 0; i < 64; i++) push(32'h1000_0000 + i);
        wait_acc(64, "max_len");
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            if (acc_data[i] !== 32'h1000_0000 + i || acc_sop[i] !== (i == 0) || acc_eop[i] !== (i == 63)) bad++;
        end
        checks++;
        if (bad != 0 || err_count !== 16'd0 || msg_count !== 16'd1) begin
            errors++;
            $display("FAIL max_len: %0d bad words err=%0d msg=%0d, required 0 0 1", bad, err_count, msg_count);
        end
    endtask

    task automatic test_back_to_back();
        int p;
        do_reset();
        push(hdr(8'h01, 8'd2)); push(32'hE000_0001); push(32'hE000_0002);
        push(hdr(8'h02, 8'd2)); push(32'hE000_0003); push(32'hE000_0004);
        wait_acc(4, "b2b");
        @(negedge clk);
        p = pop_cyc[0];
        checks++;
        if (pop_cyc.size() != 6 || pop_cyc[5] != p + 5) begin
            errors++;
            $display("FAIL b2b_pops: got %0d pops, last at +%0d, required 6 ending at +5",
                     pop_cyc.size(), pop_cyc[pop_cyc.size() - 1] - p);
        end
        checks++;
        if (acc_cyc[0] != p + 2 || acc_cyc[1] != p + 3 || acc_cyc[2] != p + 5 || acc_cyc[3] != p + 6) begin
            errors++;
            $display("FAIL b2b_timing: words at +%0d +%0d +%0d +%0d, required +2 +3 +5 +6",
                     acc_cyc[0] - p, acc_cyc[1] - p, acc_cyc[2] - p, acc_cyc[3] - p);
        end
        checks++;
        if ({acc_sop[0], acc_eop[0], acc_sop[1], acc_eop[1], acc_sop[2], acc_eop[2], acc_sop[3], acc_eop[3]}
            !== 8'b10_01_10_01 || msg_count !== 16'd2 || acc_data[3] !== 32'hE000_0004) begin
            errors++;
            $display("FAIL b2b_markers: got %b msg=%0d last=%h, required 10011001 2 e0000004",
                     {acc_sop[0], acc_eop[0], acc_sop[1], acc_eop[1], acc_sop[2], acc_eop[2], acc_sop[3], acc_eop[3]},
                     msg_count, acc_data[3]);
        end
    endtask

    task automatic test_underrun();
        do_reset();
        push(hdr(8'h21, 8'd3)); push(32'hF000_0001);
        wait_acc(1, "underrun_first");
        repeat (4) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || fsm_state !== 1'b1) begin
            errors++;
            $display("FAIL underrun_idle: valid=%b state=%b, required 0 1", out_valid, fsm_state);
        end
        push(32'hF000_0002); push(32'hF000_0003);
        wait_acc(3, "underrun");
        @(negedge clk);
        checks++;
        if (acc_data[0] !== 32'hF000_0001 || acc_data[1] !== 32'hF000_0002 || acc_data[2] !== 32'hF000_0003
            || {acc_sop[0], acc_eop[0], acc_sop[1], acc_eop[1], acc_sop[2], acc_eop[2]} !== 6'b10_00_01) begin
            errors++;
            $display("FAIL underrun_words: got %h %h %h, required f0000001 f0000002 f0000003 with 100001",
                     acc_data[0], acc_data[1], acc_data[2]);
        end
        checks++;
        if (underrun_pops != 0 || msg_count !== 16'd1) begin
            errors++;
            $display("FAIL underrun_pop_empty: pops while empty=%0d msg=%0d, required 0 1", underrun_pops, msg_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(hdr(8'h44, 8'd1)); push(32'h0000_0044);
        wait_acc(1, "mid_pre");
        @(negedge clk);
        out_ready = 1'b0;
        push(hdr(8'h55, 8'd3)); push(32'h5500_0001); push(32'h5500_0002); push(32'h5500_0003);
        wait_valid("mid");
        checks++;
        if (msg_count !== 16'd1 || out_type !== 8'h55 || out_data !== 32'h5500_0001) begin
            errors++;
            $display("FAIL mid_pre_state: msg=%0d type=%h data=%h, required 1 55 55000001", msg_count, out_type, out_data);
        end
        #2;
        reset = 1'b1;
        fifo.delete();
        refresh();
        #1;
        checks++;
        if ({out_valid, out_sop, out_eop, len_err, fsm_state} !== 5'b0
            || {out_data, out_type, msg_count, err_count} !== 72'h0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b sop=%b eop=%b data=%h type=%h msg=%0d, required all 0",
                     out_valid, out_sop, out_eop, out_data, out_type, msg_count);
        end
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        clear_logs();
        push(hdr(8'h77, 8'd2)); push(32'h7700_0001); push(32'h7700_0002);
        wait_acc(2, "mid_after");
        @(negedge clk);
        checks++;
        if (acc_data.size() != 2 || acc_data[0] !== 32'h7700_0001 || acc_data[1] !== 32'h7700_0002
            || {acc_sop[0], acc_eop[0], acc_sop[1], acc_eop[1]} !== 4'b1001 || acc_type[0] !== 8'h77
            || msg_count !== 16'd1 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_fresh: n=%0d data %h %h type %h msg=%0d err=%0d, required 2 77000001 77000002 77 1 0",
                     acc_data.size(), acc_data[0], acc_data[1], acc_type[0], msg_count, err_count);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1;
        out_ready = 1'b1;
        refresh();
        test_reset();
        test_basic();
        test_stall();
        test_len_err();
        test_max_len();
        test_back_to_back();
        test_underrun();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
